// File: rtl/exec_unit_dtypes.sv
// Shared execution-unit datatypes: the instruction-queue entry layout and
// default sizing for the per-unit instruction queues.
package exec_unit_dtypes;

  localparam int unsigned EU_IDX_W = 2;
  localparam int unsigned OPD_ADDR_W = 6;

  localparam int unsigned IQ_DEPTH_DEFAULT = 4;
  localparam int unsigned IQ_STALL_LIMIT_DEFAULT = 255;

  typedef struct packed {
    logic [EU_IDX_W-1:0]   eu_idx;
    logic [OPD_ADDR_W-1:0] addr;
  } type_opd;

  // op0m/op1m gate the operand cache lookups; an all-zero entry requests nothing.
  typedef struct packed {
    logic [3:0]            opcode;
    logic                  op0m;
    logic [OPD_ADDR_W-1:0] op0;
    logic                  op1m;
    logic [OPD_ADDR_W-1:0] op1;
    type_opd               opd;
    logic [7:0]            tag;
  } type_iqueue_entry;

endpackage

// File: rtl/iqueue_fifo_mem.sv
// DEPTH x entry register array: one synchronous write port, one
// combinational read port. Contents are not reset.
module iqueue_fifo_mem
  import exec_unit_dtypes::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH_DEFAULT,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [PTR_W-1:0]      waddr_i,
  input  type_iqueue_entry      wdata_i,
  input  logic [PTR_W-1:0]      raddr_i,
  output type_iqueue_entry      rdata_o
);

  type_iqueue_entry mem_q [DEPTH];
  type_iqueue_entry mem_d [DEPTH];

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alpu_iqueue.sv
// Per-execution-unit instruction queue ahead of the ALPU operand cache:
// circular buffer with head presentation, occupancy and a stall watchdog.
module alpu_iqueue
  import exec_unit_dtypes::*;
#(
  parameter int unsigned DEPTH       = IQ_DEPTH_DEFAULT,
  parameter int unsigned STALL_LIMIT = IQ_STALL_LIMIT_DEFAULT,
  parameter int unsigned eu_idx      = 0,
  localparam int unsigned OCC_W      = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  type_iqueue_entry             instr_i,
  input  logic                         instr_valid_i,
  output logic                         instr_ready_o,
  output type_iqueue_entry             curr_instr_o,
  output logic                         curr_valid_o,
  input  logic                         issue_i,
  input  logic                         flush_i,
  output logic [OCC_W-1:0]             occupancy_o,
  output logic                         stall_timeout_o
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);
  localparam logic [OCC_W-1:0]   DEPTH_OCC = OCC_W'(DEPTH);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               timeout_q, timeout_d;

  logic             head_valid;
  logic             issue_ok;
  logic             enq;
  logic             mem_we;
  type_iqueue_entry head_entry;

  always_comb begin
    head_valid = (occ_q != '0);
    issue_ok   = issue_i & head_valid;
    // A full queue can still accept when the head leaves in the same cycle.
    instr_ready_o = (occ_q < DEPTH_OCC) | issue_ok;
    enq           = instr_valid_i & instr_ready_o;
    mem_we        = enq & ~flush_i;

    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      occ_d  = '0;
    end else begin
      if (enq)      wptr_d = wptr_q + PTR_W'(1);
      if (issue_ok) rptr_d = rptr_q + PTR_W'(1);
      case ({enq, issue_ok})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end

    stall_d = stall_q;
    if (flush_i || !head_valid || issue_ok) begin
      stall_d = '0;
    end else if (stall_q != STALL_MAX) begin
      stall_d = stall_q + STALL_W'(1);
    end
    timeout_d = (stall_d == STALL_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      occ_q     <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      occ_q     <= occ_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  iqueue_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wptr_q),
    .wdata_i (instr_i),
    .raddr_i (rptr_q),
    .rdata_o (head_entry)
  );

  assign curr_valid_o    = head_valid;
  assign curr_instr_o    = head_valid ? head_entry : '0;
  assign occupancy_o     = occ_q;
  assign stall_timeout_o = timeout_q;

  // Foreign destinations are legal; this only makes them visible in simulation.
  always_ff @(posedge clk) begin
    if (!reset && curr_valid_o) begin
      assert (curr_instr_o.opd.eu_idx == EU_IDX_W'(eu_idx))
        else $warning("alpu_iqueue: head destination eu_idx %0d differs from owner %0d",
                      curr_instr_o.opd.eu_idx, eu_idx);
    end
  end

endmodule

// File: tb/tb_alpu_iqueue.sv
// Directed self-checking bench for alpu_iqueue (DEPTH=4, STALL_LIMIT=255).
module tb_alpu_iqueue;
  import exec_unit_dtypes::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  type_iqueue_entry instr_i;
  logic             instr_valid_i;
  logic             instr_ready_o;
  type_iqueue_entry curr_instr_o;
  logic             curr_valid_o;
  logic             issue_i;
  logic             flush_i;
  logic [OCC_W-1:0] occupancy_o;
  logic             stall_timeout_o;

  int n_cmp = 0;
  int n_err = 0;

  alpu_iqueue #(
    .DEPTH       (DEPTH),
    .STALL_LIMIT (255),
    .eu_idx      (0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .instr_i         (instr_i),
    .instr_valid_i   (instr_valid_i),
    .instr_ready_o   (instr_ready_o),
    .curr_instr_o    (curr_instr_o),
    .curr_valid_o    (curr_valid_o),
    .issue_i         (issue_i),
    .flush_i         (flush_i),
    .occupancy_o     (occupancy_o),
    .stall_timeout_o (stall_timeout_o)
  );

  always #5 clk = ~clk;

  function automatic type_iqueue_entry mk(input logic [7:0] t);
    type_iqueue_entry e;
    e            = '0;
    e.tag        = t;
    e.opcode     = t[3:0];
    e.op0m       = 1'b1;
    e.op0        = t[5:0];
    e.op1m       = t[0];
    e.op1        = ~t[5:0];
    e.opd.eu_idx = '0;
    e.opd.addr   = t[7:2];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    instr_i = '0;
    instr_valid_i = 1'b0;
    issue_i = 1'b0;
    flush_i = 1'b0;
    #12;
    chk("rst_ready", 64'(instr_ready_o), 64'(1));
    chk("rst_valid", 64'(curr_valid_o), 64'(0));
    chk("rst_instr", 64'(curr_instr_o), 64'(0));
    chk("rst_occ", 64'(occupancy_o), 64'(0));
    chk("rst_timeout", 64'(stall_timeout_o), 64'(0));
    reset = 1'b0;
    tick();

    // Test 1: fill with A..D
    for (int i = 0; i < 4; i++) begin
      instr_i = mk(8'hA1 + 8'(i));
      instr_valid_i = 1'b1;
      tick();
      chk("t1_occ", 64'(occupancy_o), 64'(i + 1));
      chk("t1_head", 64'(curr_instr_o), 64'(mk(8'hA1)));
      chk("t1_valid", 64'(curr_valid_o), 64'(1));
    end
    instr_valid_i = 1'b0;
    chk("t1_full_ready", 64'(instr_ready_o), 64'(0));

    // Test 2: full queue, enqueue E with simultaneous issue
    instr_i = mk(8'hA5);
    instr_valid_i = 1'b1;
    issue_i = 1'b1;
    #1;
    chk("t2_ready_on_issue", 64'(instr_ready_o), 64'(1));
    tick();
    chk("t2_occ", 64'(occupancy_o), 64'(4));
    instr_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_order", 64'(curr_instr_o), 64'(mk(8'hA2 + 8'(i))));
      tick();
    end
    issue_i = 1'b0;
    chk("t2_empty_valid", 64'(curr_valid_o), 64'(0));
    chk("t2_empty_instr", 64'(curr_instr_o), 64'(0));
    chk("t2_empty_occ", 64'(occupancy_o), 64'(0));

    // Test 3: one-in/one-out streaming across pointer wraps
    instr_i = mk(8'h10);
    instr_valid_i = 1'b1;
    tick();
    chk("t3_occ0", 64'(occupancy_o), 64'(1));
    issue_i = 1'b1;
    for (int i = 1; i < 10; i++) begin
      instr_i = mk(8'h10 + 8'(i));
      #1;
      chk("t3_head", 64'(curr_instr_o), 64'(mk(8'h10 + 8'(i - 1))));
      tick();
      chk("t3_occ", 64'(occupancy_o), 64'(1));
    end
    instr_valid_i = 1'b0;
    chk("t3_last", 64'(curr_instr_o), 64'(mk(8'h19)));
    tick();
    issue_i = 1'b0;
    chk("t3_drain", 64'(occupancy_o), 64'(0));

    // Test 4: stall watchdog
    instr_i = mk(8'h55);
    instr_valid_i = 1'b1;
    tick();
    instr_valid_i = 1'b0;
    chk("t4_timeout0", 64'(stall_timeout_o), 64'(0));
    for (int k = 1; k <= 260; k++) begin
      tick();
      chk("t4_timeout", 64'(stall_timeout_o), 64'(k >= 255));
    end
    issue_i = 1'b1;
    tick();
    issue_i = 1'b0;
    chk("t4_clear", 64'(stall_timeout_o), 64'(0));
    chk("t4_occ", 64'(occupancy_o), 64'(0));

    // Test 5: flush dominates simultaneous enqueue and issue
    for (int i = 0; i < 3; i++) begin
      instr_i = mk(8'hF0 + 8'(i));
      instr_valid_i = 1'b1;
      tick();
    end
    chk("t5_occ3", 64'(occupancy_o), 64'(3));
    instr_i = mk(8'hEE);
    issue_i = 1'b1;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    issue_i = 1'b0;
    instr_valid_i = 1'b0;
    chk("t5_occ", 64'(occupancy_o), 64'(0));
    chk("t5_valid", 64'(curr_valid_o), 64'(0));
    chk("t5_instr", 64'(curr_instr_o), 64'(0));
    instr_i = mk(8'hB7);
    instr_valid_i = 1'b1;
    tick();
    instr_valid_i = 1'b0;
    chk("t5_after_occ", 64'(occupancy_o), 64'(1));
    chk("t5_after_head", 64'(curr_instr_o), 64'(mk(8'hB7)));
    issue_i = 1'b1;
    tick();
    issue_i = 1'b0;

    // Test 6: asynchronous reset mid-cycle
    instr_i = mk(8'hC1);
    instr_valid_i = 1'b1;
    tick();
    instr_i = mk(8'hC2);
    tick();
    instr_valid_i = 1'b0;
    chk("t6_occ2", 64'(occupancy_o), 64'(2));
    for (int k = 0; k < 100; k++) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_occ", 64'(occupancy_o), 64'(0));
    chk("t6_rst_valid", 64'(curr_valid_o), 64'(0));
    chk("t6_rst_instr", 64'(curr_instr_o), 64'(0));
    chk("t6_rst_ready", 64'(instr_ready_o), 64'(1));
    chk("t6_rst_timeout", 64'(stall_timeout_o), 64'(0));
    #1;
    reset = 1'b0;
    tick();
    issue_i = 1'b1;
    tick();
    chk("t6_empty_issue_occ", 64'(occupancy_o), 64'(0));
    instr_i = mk(8'hD4);
    instr_valid_i = 1'b1;
    tick();
    issue_i = 1'b0;
    instr_valid_i = 1'b0;
    chk("t6_enq_issue_empty_occ", 64'(occupancy_o), 64'(1));
    chk("t6_enq_issue_empty_head", 64'(curr_instr_o), 64'(mk(8'hD4)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
